// File: rtl/coord_update_queue_if.sv
// Avalon-MM slave bus between the CPU and the coordinate update queue.
// The CPU side drives the request signals; the queue returns registered read data.
interface coord_update_queue_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/coord_update_queue.sv
// Register front end for the VGA renderer: CPU writes are queued and applied to the live
// coordinate/colour registers only during vertical blanking; also a frame counter and vblank irq.
module coord_update_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_OBJ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    coord_update_queue_if.slave    bus,
    input  logic [9:0]             vcount,
    output logic [NUM_OBJ*11-1:0]  x_cord,
    output logic [NUM_OBJ*10-1:0]  y_cord,
    output logic [7:0]             color_r,
    output logic [7:0]             color_g,
    output logic [7:0]             color_b,
    output logic [15:0]            frame_count,
    output logic                   irq
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned OBJ_END = 4 + 2 * NUM_OBJ;

    localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
    localparam logic [3:0]    AddrStat  = 4'd12;
    localparam logic [3:0]    AddrCtrl  = 4'd13;

    typedef enum logic [0:0] {StActive, StDrain} state_e;

    state_e state_q, state_d;

    logic [13:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic          irq_q;
    logic [15:0]   frame_count_q;
    logic [9:0]    vcount_q;
    logic [31:0]   readdata_q;
    logic [7:0]    color_r_q, color_g_q, color_b_q;

    logic [31:0] addr_ext;
    logic        addr_queued;
    logic        bus_wr;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        drop;
    logic        ctrl_wr;
    logic        vblank_start;
    logic [13:0] pop_entry;
    logic [3:0]  pop_addr;
    logic [9:0]  pop_data;
    logic [31:0] status;

    assign addr_ext    = {28'd0, bus.address};
    assign addr_queued = (addr_ext <= 32'd2) || ((addr_ext >= 32'd4) && (addr_ext < OBJ_END)
                         && (addr_ext < 32'd12));
    assign bus_wr      = bus.chipselect && bus.write;
    assign fifo_full   = (level_q == LevelFull);
    assign push        = bus_wr && addr_queued && !fifo_full;
    assign drop        = bus_wr && addr_queued && fifo_full;
    assign ctrl_wr     = bus_wr && (bus.address == AddrCtrl);
    assign vblank_start = (vcount == 10'd480) && (vcount_q == 10'd479);

    // The vblank-start edge itself is the first drain edge, so entry k lands k edges after it.
    assign pop = (level_q != '0) && ((state_q == StDrain) || vblank_start);

    assign pop_entry = mem[rd_ptr_q];
    assign pop_addr  = pop_entry[13:10];
    assign pop_data  = pop_entry[9:0];

    assign status = {frame_count_q, 7'b0, overflow_q, 4'b0, 4'(level_q)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StActive;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StActive: if (vblank_start) state_d = StDrain;
            StDrain:  if (vcount == 10'd0) state_d = StActive;
            default:  state_d = StActive;
        endcase
    end

    // Storage needs no reset: pointers and level discard queued entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.address, bus.writedata[9:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q    <= 1'b0;
            irq_q         <= 1'b0;
            frame_count_q <= 16'd0;
            vcount_q      <= 10'd0;
            readdata_q    <= 32'd0;
        end else begin
            vcount_q <= vcount;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ctrl_wr && bus.writedata[1]) begin
                overflow_q <= 1'b0;
            end
            if (vblank_start) begin
                irq_q         <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
            end else if (ctrl_wr && bus.writedata[0]) begin
                irq_q <= 1'b0;
            end
            if (bus.chipselect && bus.read) begin
                readdata_q <= (bus.address == AddrStat) ? status : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_r_q <= 8'h80;
            color_g_q <= 8'h00;
            color_b_q <= 8'h80;
        end else if (pop) begin
            if (pop_addr == 4'd0) color_r_q <= pop_data[7:0];
            if (pop_addr == 4'd1) color_g_q <= pop_data[7:0];
            if (pop_addr == 4'd2) color_b_q <= pop_data[7:0];
        end
    end

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        localparam logic [3:0] AddrX = 4'(4 + 2 * i);
        localparam logic [3:0] AddrY = 4'(5 + 2 * i);

        logic [10:0] x_q;
        logic [9:0]  y_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                x_q <= 11'(160 + 320 * i);
                y_q <= 10'd200;
            end else if (pop) begin
                // x is kept in hcount units, two per pixel column.
                if (pop_addr == AddrX) x_q <= {pop_data, 1'b0};
                if (pop_addr == AddrY) y_q <= pop_data;
            end
        end

        assign x_cord[11*i +: 11] = x_q;
        assign y_cord[10*i +: 10] = y_q;
    end

    assign bus.readdata = readdata_q;
    assign color_r      = color_r_q;
    assign color_g      = color_g_q;
    assign color_b      = color_b_q;
    assign frame_count  = frame_count_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_coord_update_queue.sv
// Directed bench for coord_update_queue: deferred update, ordering, overflow,
// frame counter/irq, write during drain and reset mid-drain.
module tb_coord_update_queue;

    localparam logic [43:0] XRst = {11'd1120, 11'd800, 11'd480, 11'd160};
    localparam logic [39:0] YRst = {10'd200, 10'd200, 10'd200, 10'd200};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  vcount = 10'd0;
    logic [43:0] x_cord;
    logic [39:0] y_cord;
    logic [7:0]  color_r, color_g, color_b;
    logic [15:0] frame_count;
    logic        irq;
    logic [31:0] rd;

    int n_vec = 0;
    int n_err = 0;

    coord_update_queue_if bus ();

    coord_update_queue #(
        .DEPTH   (8),
        .NUM_OBJ (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .vcount      (vcount),
        .x_cord      (x_cord),
        .y_cord      (y_cord),
        .color_r     (color_r),
        .color_g     (color_g),
        .color_b     (color_b),
        .frame_count (frame_count),
        .irq         (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        step();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    // Leaves the DUT just past the vblank-start edge (first pop already visible).
    task automatic enter_vblank();
        vcount = 10'd479;
        step();
        vcount = 10'd480;
        step();
        vcount = 10'd481;
    endtask

    task automatic leave_vblank();
        vcount = 10'd0;
        step();
        vcount = 10'd100;
        step();
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 4'd0;
        bus.writedata  = 32'd0;
        step();
        step();
        reset = 1'b0;
        vcount = 10'd100;
        step();

        // Reset values
        check("rst_x", 64'(x_cord), 64'(XRst));
        check("rst_y", 64'(y_cord), 64'(YRst));
        check("rst_rgb", 64'({color_r, color_g, color_b}), 64'(24'h800080));
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_fc", 64'(frame_count), 64'd0);
        bus_read(4'd12, rd);
        check("rst_status", 64'(rd), 64'h0);

        // Deferred update
        bus_write(4'd4, 32'd300);
        bus_read(4'd12, rd);
        check("defer_level1", 64'(rd), 64'h0000_0001);
        check("defer_hold", 64'(x_cord[10:0]), 64'd160);
        vcount = 10'd479;
        step();
        check("defer_hold479", 64'(x_cord[10:0]), 64'd160);
        vcount = 10'd480;
        step();
        check("defer_applied", 64'(x_cord[10:0]), 64'd600);
        check("defer_irq", 64'(irq), 64'd1);
        check("defer_fc", 64'(frame_count), 64'd1);
        vcount = 10'd481;
        bus_read(4'd12, rd);
        check("defer_level0", 64'(rd), 64'h0001_0000);
        bus_read(4'd0, rd);
        check("read_other_zero", 64'(rd), 64'h0);
        leave_vblank();

        // Ordering
        bus_write(4'd5, 32'd10);
        bus_write(4'd5, 32'd20);
        bus_write(4'd5, 32'd30);
        bus_write(4'd0, 32'hFF);
        check("order_active_hold", 64'(y_cord[9:0]), 64'd200);
        enter_vblank();
        check("order_y0_1", 64'(y_cord[9:0]), 64'd10);
        step();
        check("order_y0_2", 64'(y_cord[9:0]), 64'd20);
        step();
        check("order_y0_3", 64'(y_cord[9:0]), 64'd30);
        check("order_r_wait", 64'(color_r), 64'h80);
        step();
        check("order_r", 64'(color_r), 64'hFF);
        check("order_y0_final", 64'(y_cord[9:0]), 64'd30);
        leave_vblank();

        // Overflow
        for (int i = 1; i <= 9; i++) begin
            bus_write(4'd7, 32'(i));
        end
        bus_read(4'd12, rd);
        check("ovf_status", 64'(rd), 64'h0002_0108);
        check("ovf_y1_hold", 64'(y_cord[19:10]), 64'd200);
        bus_write(4'd13, 32'h2);
        bus_read(4'd12, rd);
        check("ovf_cleared", 64'(rd), 64'h0002_0008);
        enter_vblank();
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("ovf_y1_final", 64'(y_cord[19:10]), 64'd8);
        bus_read(4'd12, rd);
        check("ovf_drained", 64'(rd), 64'h0003_0000);
        leave_vblank();

        // Frame counter, irq and write during drain
        check("fc3", 64'(frame_count), 64'd3);
        check("irq_set", 64'(irq), 64'd1);
        bus_write(4'd13, 32'h1);
        check("irq_clear", 64'(irq), 64'd0);
        enter_vblank();
        vcount = 10'd500;
        step();
        bus_write(4'd8, 32'd50);
        step();
        check("drain_write_x2", 64'(x_cord[32:22]), 64'd100);
        check("fc4", 64'(frame_count), 64'd4);
        check("irq_reset_again", 64'(irq), 64'd1);
        leave_vblank();

        // Reset mid-drain
        bus_write(4'd1, 32'h11);
        bus_write(4'd2, 32'h22);
        bus_write(4'd6, 32'd7);
        for (int i = 1; i <= 5; i++) begin
            bus_write(4'd11, 32'(i));
        end
        vcount = 10'd479;
        step();
        vcount = 10'd480;
        bus_read(4'd12, rd);
        check("mid_status8", 64'(rd), 64'h0004_0008);
        check("mid_g", 64'(color_g), 64'h11);
        vcount = 10'd481;
        step();
        check("mid_b", 64'(color_b), 64'h22);
        step();
        check("mid_x1", 64'(x_cord[21:11]), 64'd14);
        #5;
        reset = 1'b1;
        #1;
        check("mid_async_x", 64'(x_cord), 64'(XRst));
        check("mid_async_rgb", 64'({color_r, color_g, color_b}), 64'(24'h800080));
        step();
        step();
        reset = 1'b0;
        vcount = 10'd100;
        step();
        bus_read(4'd12, rd);
        check("mid_status0", 64'(rd), 64'h0);
        enter_vblank();
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("post_y", 64'(y_cord), 64'(YRst));
        check("post_x", 64'(x_cord), 64'(XRst));
        check("post_fc", 64'(frame_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
